// File: rtl/mtile_writer.sv
// Host write path for tile mode: buffers one tile-map or tile-pixel byte write and
// commits it to screen RAM through the shared req/gnt arbiter. Optional macro: MTILE_WR_AUTOINC_EN.
module mtile_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_reg,
  input  logic [7:0]  cpu_data,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE} state_t;

  state_t     state;
  logic [4:0] cur_x;
  logic [3:0] cur_y;
  logic [7:0] tile_sel;
  logic [6:0] ptr;

  logic is_map, is_pix, cmd, accept, drop;

  assign is_map = cpu_we && (cpu_reg == 3'd2);
  assign is_pix = cpu_we && (cpu_reg == 3'd5);
  assign cmd    = is_map || is_pix;
  assign accept = cmd && (state == S_IDLE);
  assign drop   = cmd && (state != S_IDLE);

`ifdef MTILE_WR_AUTOINC_EN
  // Map cursor walks a 20x15 raster; out-of-range values fold back on the next step.
  logic       x_wrap;
  logic [4:0] x_adv;
  logic [3:0] y_adv;
  logic [6:0] ptr_adv;
  logic [7:0] tsel_adv;
  always_comb begin
    x_wrap   = (cur_x >= 5'd19);
    x_adv    = x_wrap ? 5'd0 : cur_x + 5'd1;
    y_adv    = !x_wrap ? cur_y : ((cur_y >= 4'd14) ? 4'd0 : cur_y + 4'd1);
    ptr_adv  = ptr + 7'd1;
    tsel_adv = (ptr == 7'd127) ? tile_sel + 8'd1 : tile_sel;
  end
`endif

  // Cursor/pointer registers; host writes land regardless of busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x    <= '0;
      cur_y    <= '0;
      tile_sel <= '0;
      ptr      <= '0;
      ovf      <= 1'b0;
    end else begin
      if (cpu_we) begin
        case (cpu_reg)
          3'd0: cur_x    <= cpu_data[4:0];
          3'd1: cur_y    <= cpu_data[3:0];
          3'd3: tile_sel <= cpu_data;
          3'd4: ptr      <= cpu_data[6:0];
          default: ;
        endcase
      end
`ifdef MTILE_WR_AUTOINC_EN
      if (accept && is_map) begin
        cur_x <= x_adv;
        cur_y <= y_adv;
      end
      if (accept && is_pix) begin
        ptr      <= ptr_adv;
        tile_sel <= tsel_adv;
      end
`endif
      if (drop)
        ovf <= 1'b1;
      else if (cpu_we && cpu_reg == 3'd7)
        ovf <= 1'b0;
    end
  end

  // Address/data are captured from the pre-advance cursors at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          mem_addr  <= is_map ? {1'b1, 6'b0, cur_y, cur_x} : {1'b0, tile_sel, ptr};
          mem_wdata <= cpu_data;
          mem_req   <= 1'b1;
          busy      <= 1'b1;
          state     <= S_REQ;
        end
        S_REQ: if (mem_gnt) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b1;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          mem_we <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mtile_writer.sv
// Directed plus randomized bench for mtile_writer against a cursor/pointer reference model.
module tb_mtile_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_we = 1'b0;
  logic [2:0]  cpu_reg = '0;
  logic [7:0]  cpu_data = '0;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        ovf;

`ifdef MTILE_WR_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  int  m_x, m_y, m_t, m_p;
  bit  m_ovf;

  mtile_writer dut (
    .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_reg(cpu_reg), .cpu_data(cpu_data),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_x = 0; m_y = 0; m_t = 0; m_p = 0; m_ovf = 0;
  endtask

  task automatic m_reg(input int r, input int d);
    case (r)
      0: m_x = d % 32;
      1: m_y = d % 16;
      3: m_t = d % 256;
      4: m_p = d % 128;
      7: m_ovf = 0;
      default: ;
    endcase
  endtask

  // Returns the address the command should write and advances the model cursors.
  task automatic m_cmd(input int r, output logic [15:0] ea);
    int a;
    if (r == 2) begin
      a = 32768 + m_y * 32 + m_x;
      if (AUTO) begin
        if (m_x >= 19) begin
          m_x = 0;
          m_y = (m_y >= 14) ? 0 : m_y + 1;
        end else m_x = m_x + 1;
      end
    end else begin
      a = m_t * 128 + m_p;
      if (AUTO) begin
        if (m_p == 127) begin
          m_p = 0;
          m_t = (m_t + 1) % 256;
        end else m_p = m_p + 1;
      end
    end
    ea = a[15:0];
  endtask

  task automatic wr(input int r, input int d);
    cpu_we = 1'b1; cpu_reg = r[2:0]; cpu_data = d[7:0];
    @(posedge clk); #1;
    cpu_we = 1'b0;
    m_reg(r, d);
    chk("ovf_after_reg", {15'b0, ovf}, {15'b0, m_ovf});
    chk("idle_after_reg", {14'b0, busy, mem_req}, 16'h0);
  endtask

  // Issue an accepted command, withhold gnt for k cycles, optionally drop a
  // second command in the grant cycle and write a cursor register mid-wait.
  task automatic cmd(input int r, input int d, input int k, input bit drop, input bit midw);
    logic [15:0] ea;
    int sel, rs, dv;
    m_cmd(r, ea);
    cpu_we = 1'b1; cpu_reg = r[2:0]; cpu_data = d[7:0]; mem_gnt = 1'b0;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    chk("req_busy_N", {14'b0, busy, mem_req}, 16'h3);
    chk("we_low_N", {15'b0, mem_we}, 16'h0);
    chk("addr_N", mem_addr, ea);
    chk("data_N", {8'b0, mem_wdata}, {8'b0, d[7:0]});
    for (int i = 0; i < k; i++) begin
      if (i == 1 && midw) begin
        sel = $urandom_range(0, 3);
        rs = (sel < 2) ? sel : sel + 1;
        dv = $urandom_range(0, 255);
        cpu_we = 1'b1; cpu_reg = rs[2:0]; cpu_data = dv[7:0];
        m_reg(rs, dv);
      end
      @(posedge clk); #1;
      cpu_we = 1'b0;
      chk("req_hold", {14'b0, busy, mem_req}, 16'h3);
      chk("we_hold", {15'b0, mem_we}, 16'h0);
      chk("addr_hold", mem_addr, ea);
    end
    mem_gnt = 1'b1;
    if (drop) begin
      cpu_we = 1'b1; cpu_reg = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd5; cpu_data = ~d[7:0];
      m_ovf = 1;
    end
    @(posedge clk); #1;
    cpu_we = 1'b0; mem_gnt = 1'b0;
    chk("we_pulse", {15'b0, mem_we}, 16'h1);
    chk("req_drop_write", {14'b0, busy, mem_req}, 16'h2);
    chk("addr_write", mem_addr, ea);
    chk("data_write", {8'b0, mem_wdata}, {8'b0, d[7:0]});
    chk("ovf_write", {15'b0, ovf}, {15'b0, m_ovf});
    @(posedge clk); #1;
    chk("done", {13'b0, busy, mem_req, mem_we}, 16'h0);
    chk("addr_kept", mem_addr, ea);
  endtask

  initial begin
    logic [15:0] ea;
    int op, k;
    m_reset();
    #12;
    chk("rst_outputs", {12'b0, mem_req, mem_we, busy, ovf}, 16'h0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_data", {8'b0, mem_wdata}, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // basic map write, then follow-up to expose cursor advance
    wr(0, 3); wr(1, 2);
    cmd(2, 8'h41, 0, 0, 0);
    cmd(2, 8'h42, 0, 0, 0);

    // raster wrap at bottom-right corner
    wr(0, 19); wr(1, 14);
    cmd(2, 8'h10, 0, 0, 0);
    cmd(2, 8'h11, 0, 0, 0);

    // tile pointer wrap into next tile
    wr(3, 7); wr(4, 127);
    cmd(5, 8'hAA, 0, 0, 0);
    cmd(5, 8'h55, 0, 0, 0);

    // withheld grant with a dropped command, then clear
    wr(0, 5); wr(1, 1);
    cmd(2, 8'h77, 5, 1, 0);
    cmd(2, 8'h78, 0, 0, 0);
    wr(7, 0);

    // reset during WRITE
    wr(0, 9);
    m_cmd(2, ea);
    mem_gnt = 1'b1;
    cpu_we = 1'b1; cpu_reg = 3'd2; cpu_data = 8'hC3;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_we", {15'b0, mem_we}, 16'h1);
    chk("pre_rst_addr", mem_addr, ea);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {12'b0, mem_req, mem_we, busy, ovf}, 16'h0);
    chk("midrst_addr", mem_addr, 16'h0000);
    m_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", {14'b0, mem_we, busy}, 16'h0);
    end
    mem_gnt = 1'b0;
    cmd(2, 8'h01, 0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(0, 9);
      k = $urandom_range(0, 4);
      case (op)
        0: wr(0, $urandom_range(0, 255));
        1: wr(1, $urandom_range(0, 255));
        2: wr(3, $urandom_range(0, 255));
        3: wr(4, ($urandom_range(0, 3) == 0) ? 127 : $urandom_range(0, 255));
        4, 5: cmd(2, $urandom_range(0, 255), k, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        6, 7: cmd(5, $urandom_range(0, 255), k, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        8: wr(7, $urandom_range(0, 255));
        default: wr(6, $urandom_range(0, 255));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
